// File: rtl/mp_add_pkg.sv
// Shared types and sizing helpers for the multi-precision add/subtract sequencer.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Word-index counter width: $clog2(words), but never narrower than one bit.
    function automatic int idx_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/adder_n.sv
// Plain N-bit ripple adder with carry in/out; the shared word datapath of mp_add_seq.
module adder_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract: one BITS-wide adder reused over WORDS cycles.
// Optional signed-overflow output rsp_ovf is built when MP_ADD_OVF_EN is defined.
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int BITS  = 8,
    parameter int WORDS = 4,
    localparam int W    = BITS * WORDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_sub,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_sum,
    output logic         rsp_cout
`ifdef MP_ADD_OVF_EN
    ,
    output logic         rsp_ovf
`endif
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // req_ready is high only in IDLE; rsp_valid is high only in DONE, and the
    // response stays unchanged until the edge where rsp_ready is seen.

    localparam int             IW   = idx_width(WORDS);
    localparam logic [IW-1:0]  LAST = IW'(WORDS - 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry;
    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    res;
    logic            ready_q;
    logic            valid_q;

    logic [BITS-1:0] a_word;
    logic [BITS-1:0] b_word;
    logic [BITS-1:0] sum_word;
    logic            cout_word;

    assign a_word = op_a[BITS*int'(idx) +: BITS];
    assign b_word = op_b[BITS*int'(idx) +: BITS];

    adder_n #(
        .N    (BITS)
    ) u_adder (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry),
        .sum  (sum_word),
        .cout (cout_word)
    );

`ifdef MP_ADD_OVF_EN
    logic ovf_q;
    logic msb_cin;

    // Carry into the top bit recovered from its operand and sum bits.
    assign msb_cin = a_word[BITS-1] ^ b_word[BITS-1] ^ sum_word[BITS-1];
    assign rsp_ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
`ifdef MP_ADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_a    <= req_a;
                        op_b    <= req_sub ? ~req_b : req_b;
                        carry   <= req_sub;
                        idx     <= '0;
                        ready_q <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    res[BITS*int'(idx) +: BITS] <= sum_word;
                    carry <= cout_word;
                    if (idx == LAST) begin
                        valid_q <= 1'b1;
                        state   <= DONE;
`ifdef MP_ADD_OVF_EN
                        ovf_q   <= msb_cin ^ cout_word;
`endif
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = valid_q;
    assign rsp_sum   = res;
    assign rsp_cout  = carry;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (BITS=8, WORDS=4); define MP_ADD_OVF_EN to cover rsp_ovf.
module tb_mp_add_seq;

    localparam int BITS  = 8;
    localparam int WORDS = 4;
    localparam int W     = BITS * WORDS;
    localparam int LIMIT = 100;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_sub;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
`ifdef MP_ADD_OVF_EN
    logic         rsp_ovf;
`endif

    int checks = 0;
    int errors = 0;

    // Each entry is {ovf, cout, sum}.
    logic [W+1:0] exp_q[$];

    mp_add_seq #(
        .BITS      (BITS),
        .WORDS     (WORDS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef MP_ADD_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    // Clock / reset
    always #5 clk = ~clk;

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        logic [W:0] full;
        logic [W:0] one;
        logic       ovf;
        one = 1;
        if (sub) begin
            full = {1'b0, a} + {1'b0, ~b} + one;
            ovf  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, b};
            ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end
        return {ovf, full};
    endfunction

    // Driver: wait for req_ready, present one request, push its expectation on accept.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                        input bit push);
        int n = 0;
        while (req_ready !== 1'b1 && n < LIMIT) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: req_ready=%b required 1 after %0d cycles", req_ready, n);
        end
        req_a     = a;
        req_b     = b;
        req_sub   = sub;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_sub   = 1'b0;
        if (push) exp_q.push_back(model(a, b, sub));
    endtask

    // Scoreboard side: wait for a response, hold it for 'hold' cycles, then handshake.
    task automatic collect(input int hold);
        int           lat = 0;
        logic [W+1:0] exp;
        while (rsp_valid !== 1'b1 && lat < LIMIT) begin
            @(posedge clk); #1;
            lat++;
        end
        exp = exp_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout: rsp_valid=%b required 1 within %0d cycles", rsp_valid, LIMIT);
            return;
        end
        checks++;
        if (lat !== WORDS) begin
            errors++;
            $display("FAIL latency: got %0d cycles required %0d", lat, WORDS);
        end
        for (int i = 0; i <= hold; i++) begin
            checks++;
            if (rsp_sum !== exp[W-1:0]) begin
                errors++;
                $display("FAIL rsp_sum: got %h required %h (hold %0d)", rsp_sum, exp[W-1:0], i);
            end
            checks++;
            if (rsp_cout !== exp[W]) begin
                errors++;
                $display("FAIL rsp_cout: got %b required %b (hold %0d)", rsp_cout, exp[W], i);
            end
`ifdef MP_ADD_OVF_EN
            checks++;
            if (rsp_ovf !== exp[W+1]) begin
                errors++;
                $display("FAIL rsp_ovf: got %b required %b (hold %0d)", rsp_ovf, exp[W+1], i);
            end
`endif
            checks++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL done_hold: rsp_valid=%b req_ready=%b required 1/0 (hold %0d)",
                         rsp_valid, req_ready, i);
            end
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake: rsp_valid=%b req_ready=%b required 0/1",
                     rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req_valid = 1'b1;
        req_a     = 32'hDEAD_BEEF;
        req_b     = 32'h1234_5678;
        req_sub   = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        rst       = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: req_ready=%b rsp_valid=%b required 1/0", req_ready, rsp_valid);
        end
        checks++;
        if (rsp_sum !== '0 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: sum=%h cout=%b required 0/0", rsp_sum, rsp_cout);
        end
`ifdef MP_ADD_OVF_EN
        checks++;
        if (rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b required 0", rsp_ovf);
        end
`endif
    endtask

    task automatic test_add();
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b1);
        collect(0);
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        collect(0);
        send(32'h00FF_00FF, 32'h0001_0001, 1'b0, 1'b1);
        collect(0);
    endtask

    task automatic test_sub();
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
        collect(0);
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1);
        collect(0);
        send(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1);
        collect(0);
    endtask

    task automatic test_backpressure();
        send(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b1);
        // A competing request is held up across the whole stall.
        req_a     = 32'hAAAA_0000;
        req_b     = 32'h0000_5555;
        req_sub   = 1'b1;
        req_valid = 1'b1;
        collect(10);
        @(posedge clk); #1;
        req_valid = 1'b0;
        exp_q.push_back(model(32'hAAAA_0000, 32'h0000_5555, 1'b1));
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL held_req_accept: req_ready=%b required 0", req_ready);
        end
        collect(0);
    endtask

    task automatic test_reset_mid_run();
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_rst_hs: req_ready=%b rsp_valid=%b required 1/0",
                     req_ready, rsp_valid);
        end
        checks++;
        if (rsp_sum !== '0 || rsp_cout !== 1'b0) begin
            errors++;
            $display("FAIL midrun_rst_data: sum=%h cout=%b required 0/0", rsp_sum, rsp_cout);
        end
        repeat (WORDS + 2) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrun_no_rsp: rsp_valid=%b required 0", rsp_valid);
        end
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        collect(0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        for (int i = 0; i < 8; i++) begin
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            send(a, b, s, 1'b1);
            collect($urandom_range(0, 3));
        end
    endtask

`ifdef MP_ADD_OVF_EN
    task automatic test_ovf();
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        collect(0);
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1);
        collect(0);
        send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b1);
        collect(0);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        collect(0);
    endtask
`endif

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
`ifdef MP_ADD_OVF_EN
        test_ovf();
`endif
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
